carryadder_sliced: RTL and testbench
====================================

Name: carryadder_sliced

Overview:
- Parametrised successor to the team's 8-bit carry adder: WIDTH-bit add/subtract with carry-in, sum, carry-out and zero flag.
- Operands are processed SLICE bits per clock. A ripple chain is registered between slices, so timing holds at large WIDTH.
- Same rx_/tx_ handshake style as the 8-bit adder.
- Sits as an arithmetic leaf under the ALU/accumulator datapath.

Parameters:
- WIDTH, 32, operand/sum width in bits. Must be a multiple of SLICE, ≥ SLICE.
- SLICE, 8, bits added per clock. Must be ≥ 1.
- NSLICE (localparam), WIDTH/SLICE, number of RUN cycles.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- rx_enable  in  1  block enable. Low means commands are ignored; an in-flight operation continues.
- rx_write  in  1  command write qualifier.
- rx_strobe  in  1  command strobe. Accept = rx_enable & rx_write & rx_strobe & tx_ready.
- rx_subtract  in  1  1 means addend0 − addend1 (addend1 inverted).
- rx_carryflag  in  1  carry-in. For subtract, 1 means no borrow.
- rx_addend0  in  WIDTH  operand A.
- rx_addend1  in  WIDTH  operand B.
- tx_sum  out  WIDTH  result.
- tx_carryflag  out  1  carry-out of MSB slice.
- tx_zeroflag  out  1  1 when tx_sum == 0.
- tx_ready  out  1  idle, command can be accepted.
- tx_done  out  1  one-cycle pulse when the result becomes valid.

Behaviour:
- Reset (async assert, sync-release by upstream):
  - tx_sum=0, tx_carryflag=0, tx_zeroflag=0, tx_ready=1, tx_done=0.
  - State IDLE, slice counter 0, internal operand/carry registers 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - tx_ready=1.
  - On accept, capture A, B^{WIDTH{rx_subtract}} and carry=rx_carryflag.
  - Clear counter; go to RUN; tx_ready=0 from the next cycle.
- RUN:
  - Each cycle, add slice[k] of A and B plus the carry register.
  - Write SLICE result bits into the internal sum at slice k; register the carry-out.
  - Increment k. LSB slice first.
  - When k == NSLICE−1 is processed, go to DONE.
- DONE (one cycle):
  - Copy the internal sum to tx_sum and the final carry to tx_carryflag.
  - tx_zeroflag = (sum == 0). tx_done=1 this cycle only; tx_ready=1.
  - Next state IDLE.
- An accept in the DONE cycle is legal; it is treated as an IDLE accept (back-to-back throughput).
- Latency: the accept edge is cycle 0. tx_done and the valid outputs are visible after edge NSLICE+1. Throughput is one op per NSLICE+1 cycles.
- tx_sum/flags hold their last value until the next DONE. They are not cleared on accept.
- Strobes while tx_ready=0 are ignored: no queuing, no error.
- rx_enable low during RUN does not stall; the operation completes.
- Width rules:
  - Carry-out is taken from the full (SLICE+1)-bit slice add.
  - Subtract result is two's-complement mod 2^WIDTH.
  - For subtract, tx_carryflag=1 means no borrow.
- SLICE == WIDTH is legal: single RUN cycle.
- Reset mid-RUN aborts immediately to the reset values; the partial result is discarded.
- Illegal parameters (WIDTH % SLICE ≠ 0) stop elaboration via a generate-time error.

Optional Feature:
- Macro CARRYADDER_SLICED_OVERFLOW_EN.
- Defined:
  - Adds output port tx_overflowflag (1 bit), signed two's-complement overflow, computed from the MSB slice as carry-into-MSB XOR carry-out-of-MSB.
  - Updated in DONE together with the other flags; reset value 0.
- Undefined: the port is absent and no overflow logic is built.

Test Plan:
- Reset, WIDTH=32, SLICE=8: assert aresetn=0 mid-RUN → all outputs at reset values immediately. After release, tx_ready=1 and the next op completes correctly.
- Add with ripple across slices, WIDTH=32, SLICE=8: A=0x0000_00FF, B=0x0000_0001, cin=0 → tx_sum=0x0000_0100, carry=0, zero=0. tx_done 5 cycles after accept.
- Full carry chain: A=0xFFFF_FFFF, B=0x0000_0000, cin=1 → tx_sum=0, tx_carryflag=1, tx_zeroflag=1.
- Subtract: A=5, B=7, subtract=1, cin=1 → tx_sum=0xFFFF_FFFE, tx_carryflag=0 (borrow). Then A=7, B=5 → sum 2, carry=1.
- Handshake:
  - Strobe during RUN with different operands is ignored; the result matches the first op.
  - Accept in the DONE cycle starts the second op with no idle gap.
  - rx_enable=0 with strobe causes no accept.
- Overflow (macro defined): A=0x7FFF_FFFF, B=1, add, cin=0 → tx_overflowflag=1, sum=0x8000_0000. SLICE=WIDTH=32 run gives the same result with tx_done 2 cycles after accept.

Source files
------------

// File: rtl/carryadder_sliced.sv
// carryadder_sliced: WIDTH-bit add/subtract computed SLICE bits per clock.
// A registered ripple carry between slices keeps the critical path at one
// SLICE-bit adder regardless of WIDTH. LSB slice first; one op per NSLICE+1
// cycles, with back-to-back accepts allowed in the DONE cycle.
// Optional: define CARRYADDER_SLICED_OVERFLOW_EN to add tx_overflowflag
// (signed two's-complement overflow taken from the MSB slice).

// Combinational SLICE-bit adder with carry-in and carry-out.
module carryadder_sliced_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             c_i,
    output logic [SLICE-1:0] s_o,
    output logic             c_o
);
    logic [SLICE:0] full;

    // Full (SLICE+1)-bit add; the top bit is the slice carry-out.
    assign full = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, c_i};
    assign s_o  = full[SLICE-1:0];
    assign c_o  = full[SLICE];
endmodule

module carryadder_sliced #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             rx_enable,
    input  logic             rx_write,
    input  logic             rx_strobe,
    input  logic             rx_subtract,
    input  logic             rx_carryflag,
    input  logic [WIDTH-1:0] rx_addend0,
    input  logic [WIDTH-1:0] rx_addend1,
    output logic [WIDTH-1:0] tx_sum,
    output logic             tx_carryflag,
    output logic             tx_zeroflag,
`ifdef CARRYADDER_SLICED_OVERFLOW_EN
    output logic             tx_overflowflag,
`endif
    output logic             tx_ready,
    output logic             tx_done
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] KLAST = CW'(NSLICE - 1);

    // Refuse to build with a width that does not split into whole slices.
    generate
        if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("carryadder_sliced: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                        state_q;
    logic [CW-1:0]                 k_q;
    logic [NSLICE-1:0][SLICE-1:0]  a_q;
    logic [NSLICE-1:0][SLICE-1:0]  b_q;
    logic [NSLICE-1:0][SLICE-1:0]  sum_q;
    logic                          carry_q;

    logic                          accept;
    logic [SLICE-1:0]              a_sl;
    logic [SLICE-1:0]              b_sl;
    logic [SLICE-1:0]              s_sl;
    logic                          c_out;

`ifdef CARRYADDER_SLICED_OVERFLOW_EN
    logic                          ovf_q;
    logic                          ovf_d;
`endif

    // tx_ready is only high in IDLE and DONE, so accept never fires mid-RUN.
    assign accept = rx_enable & rx_write & rx_strobe & tx_ready;

    // Select operand slice k for this RUN cycle.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (k_q == CW'(i)) begin
                a_sl = a_q[i];
                b_sl = b_q[i];
            end
        end
    end

    carryadder_sliced_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i (a_sl),
        .b_i (b_sl),
        .c_i (carry_q),
        .s_o (s_sl),
        .c_o (c_out)
    );

`ifdef CARRYADDER_SLICED_OVERFLOW_EN
    // Carry into the MSB is recovered from the MSB sum bit; overflow is
    // that carry XOR the carry out of the MSB.
    always_comb begin
        ovf_d = (a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ s_sl[SLICE-1]) ^ c_out;
    end
`endif

    // Control FSM, slice datapath and registered outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= S_IDLE;
            k_q             <= '0;
            a_q             <= '0;
            b_q             <= '0;
            sum_q           <= '0;
            carry_q         <= 1'b0;
            tx_sum          <= '0;
            tx_carryflag    <= 1'b0;
            tx_zeroflag     <= 1'b0;
            tx_ready        <= 1'b1;
            tx_done         <= 1'b0;
`ifdef CARRYADDER_SLICED_OVERFLOW_EN
            ovf_q           <= 1'b0;
            tx_overflowflag <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                end
                S_RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (k_q == CW'(i)) sum_q[i] <= s_sl;
                    end
                    carry_q <= c_out;
                    k_q     <= k_q + 1'b1;
                    if (k_q == KLAST) begin
`ifdef CARRYADDER_SLICED_OVERFLOW_EN
                        ovf_q    <= ovf_d;
`endif
                        state_q  <= S_DONE;
                        tx_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    tx_sum       <= sum_q;
                    tx_carryflag <= carry_q;
                    tx_zeroflag  <= (sum_q == '0);
                    tx_done      <= 1'b1;
`ifdef CARRYADDER_SLICED_OVERFLOW_EN
                    tx_overflowflag <= ovf_q;
`endif
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    tx_ready <= 1'b1;
                end
            endcase
            // Accept from IDLE or DONE; overrides the DONE->IDLE move so a
            // command in the DONE cycle starts with no idle gap.
            if (accept) begin
                a_q      <= rx_addend0;
                b_q      <= rx_addend1 ^ {WIDTH{rx_subtract}};
                carry_q  <= rx_carryflag;
                k_q      <= '0;
                state_q  <= S_RUN;
                tx_ready <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_carryadder_sliced.sv
// Bench for carryadder_sliced: directed cases, random ops against an
// arithmetic reference, handshake corner cases and a SLICE==WIDTH instance.
module tb_carryadder_sliced;
    localparam int W  = 32;
    localparam int S  = 8;
    localparam int NS = W / S;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic         rx_enable, rx_write, rx_strobe, rx_subtract, rx_carryflag;
    logic [W-1:0] rx_addend0, rx_addend1, tx_sum;
    logic         tx_carryflag, tx_zeroflag, tx_ready, tx_done;
    logic         u_enable, u_write, u_strobe, u_subtract, u_carryflag;
    logic [W-1:0] u_addend0, u_addend1, u_sum;
    logic         u_carryout, u_zero, u_ready, u_done;
`ifdef CARRYADDER_SLICED_OVERFLOW_EN
    logic         tx_overflowflag, u_overflow;
`endif

    int nvec = 0;
    int nerr = 0;

    carryadder_sliced #(.WIDTH(W), .SLICE(S)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rx_enable(rx_enable), .rx_write(rx_write), .rx_strobe(rx_strobe),
        .rx_subtract(rx_subtract), .rx_carryflag(rx_carryflag),
        .rx_addend0(rx_addend0), .rx_addend1(rx_addend1),
        .tx_sum(tx_sum), .tx_carryflag(tx_carryflag), .tx_zeroflag(tx_zeroflag),
`ifdef CARRYADDER_SLICED_OVERFLOW_EN
        .tx_overflowflag(tx_overflowflag),
`endif
        .tx_ready(tx_ready), .tx_done(tx_done)
    );

    carryadder_sliced #(.WIDTH(W), .SLICE(W)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .rx_enable(u_enable), .rx_write(u_write), .rx_strobe(u_strobe),
        .rx_subtract(u_subtract), .rx_carryflag(u_carryflag),
        .rx_addend0(u_addend0), .rx_addend1(u_addend1),
        .tx_sum(u_sum), .tx_carryflag(u_carryout), .tx_zeroflag(u_zero),
`ifdef CARRYADDER_SLICED_OVERFLOW_EN
        .tx_overflowflag(u_overflow),
`endif
        .tx_ready(u_ready), .tx_done(u_done)
    );

    // Reference: {carry, sum} of a + (b or ~b) + cin in WIDTH+1 bits.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, b, input logic sub, cin);
        logic [W-1:0] bb;
        bb = sub ? ~b : b;
        return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    endfunction

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic sub, cin);
        logic [W-1:0] bb;
        logic [W:0]   r;
        bb = sub ? ~b : b;
        r  = ref_add(a, b, sub, cin);
        return (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    endfunction

    task automatic run_op(input logic [W-1:0] a, b, input logic sub, cin,
                          input bit drop_en, output int lat);
        @(negedge aclk);
        rx_enable = 1'b1; rx_write = 1'b1; rx_strobe = 1'b1;
        rx_subtract = sub; rx_carryflag = cin; rx_addend0 = a; rx_addend1 = b;
        @(posedge aclk); #1;
        rx_strobe = 1'b0;
        if (drop_en) rx_enable = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge aclk); #1;
            if (tx_done === 1'b1) begin lat = i; break; end
        end
        rx_enable = 1'b1;
    endtask

    task automatic run_op_u(input logic [W-1:0] a, b, input logic sub, cin, output int lat);
        @(negedge aclk);
        u_enable = 1'b1; u_write = 1'b1; u_strobe = 1'b1;
        u_subtract = sub; u_carryflag = cin; u_addend0 = a; u_addend1 = b;
        @(posedge aclk); #1;
        u_strobe = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge aclk); #1;
            if (u_done === 1'b1) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        rx_enable = 1'b0; rx_write = 1'b0; rx_strobe = 1'b0; rx_subtract = 1'b0;
        rx_carryflag = 1'b0; rx_addend0 = '0; rx_addend1 = '0;
        u_enable = 1'b0; u_write = 1'b0; u_strobe = 1'b0; u_subtract = 1'b0;
        u_carryflag = 1'b0; u_addend0 = '0; u_addend1 = '0;
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        nvec++;
        if ({tx_sum, tx_carryflag, tx_zeroflag, tx_ready, tx_done} !== {{W{1'b0}}, 4'b0010}) begin
            nerr++;
            $display("FAIL reset_state got sum=%h c=%b z=%b rdy=%b done=%b exp sum=0 c=0 z=0 rdy=1 done=0",
                     tx_sum, tx_carryflag, tx_zeroflag, tx_ready, tx_done);
        end
`ifdef CARRYADDER_SLICED_OVERFLOW_EN
        nvec++;
        if (tx_overflowflag !== 1'b0) begin
            nerr++; $display("FAIL reset_ovf got=%b exp=0", tx_overflowflag);
        end
`endif
        aresetn = 1'b1;
        @(negedge aclk);
        nvec++;
        if (tx_ready !== 1'b1) begin nerr++; $display("FAIL ready_after_reset got=%b exp=1", tx_ready); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[4] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'd5, 32'd7};
        logic [W-1:0] tb[4] = '{32'h0000_0001, 32'h0000_0000, 32'd7, 32'd5};
        logic         ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic         tc[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [W-1:0] es[4] = '{32'h0000_0100, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0002};
        logic         ec[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         ez[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], ts[i], tc[i], 1'b0, lat);
            nvec++;
            if ({tx_sum, tx_carryflag, tx_zeroflag} !== {es[i], ec[i], ez[i]} || lat != NS + 1) begin
                nerr++;
                $display("FAIL directed_%0d got sum=%h c=%b z=%b lat=%0d exp sum=%h c=%b z=%b lat=%0d",
                         i, tx_sum, tx_carryflag, tx_zeroflag, lat, es[i], ec[i], ez[i], NS + 1);
            end
        end
`ifdef CARRYADDER_SLICED_OVERFLOW_EN
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, lat);
        nvec++;
        if ({tx_sum, tx_overflowflag, tx_carryflag} !== {32'h8000_0000, 2'b10}) begin
            nerr++;
            $display("FAIL overflow got sum=%h v=%b c=%b exp sum=80000000 v=1 c=0",
                     tx_sum, tx_overflowflag, tx_carryflag);
        end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         sub, cin;
        logic [W:0]   r;
        int           lat;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = ~a;
                default: b = $urandom;
            endcase
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            r = ref_add(a, b, sub, cin);
            run_op(a, b, sub, cin, 1'b0, lat);
            nvec++;
            if ({tx_sum, tx_carryflag, tx_zeroflag} !== {r[W-1:0], r[W], (r[W-1:0] == '0)} ||
                lat != NS + 1) begin
                nerr++;
                $display("FAIL random a=%h b=%h sub=%b cin=%b got sum=%h c=%b z=%b lat=%0d exp sum=%h c=%b lat=%0d",
                         a, b, sub, cin, tx_sum, tx_carryflag, tx_zeroflag, lat, r[W-1:0], r[W], NS + 1);
            end
`ifdef CARRYADDER_SLICED_OVERFLOW_EN
            nvec++;
            if (tx_overflowflag !== ref_ovf(a, b, sub, cin)) begin
                nerr++;
                $display("FAIL random_ovf a=%h b=%h sub=%b got=%b exp=%b",
                         a, b, sub, tx_overflowflag, ref_ovf(a, b, sub, cin));
            end
`endif
        end
    endtask

    task automatic test_ignore_strobe();
        logic [W:0] r;
        int lat, extra;
        r = ref_add(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);
        @(negedge aclk);
        rx_enable = 1'b1; rx_write = 1'b1; rx_strobe = 1'b1; rx_subtract = 1'b0;
        rx_carryflag = 1'b1; rx_addend0 = 32'h1234_5678; rx_addend1 = 32'h0FED_CBA9;
        @(posedge aclk); #1;
        rx_addend0 = 32'hDEAD_BEEF; rx_addend1 = 32'h1111_1111; rx_subtract = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge aclk); #1;
            if (i == 2) rx_strobe = 1'b0;
            if (tx_done === 1'b1) begin lat = i; break; end
        end
        nvec++;
        if (tx_sum !== r[W-1:0] || tx_carryflag !== r[W] || lat != NS + 1) begin
            nerr++;
            $display("FAIL strobe_in_run got sum=%h c=%b lat=%0d exp sum=%h c=%b lat=%0d",
                     tx_sum, tx_carryflag, lat, r[W-1:0], r[W], NS + 1);
        end
        extra = 0;
        for (int i = 0; i < 2 * NS + 2; i++) begin
            @(posedge aclk); #1;
            if (tx_done === 1'b1) extra++;
        end
        nvec++;
        if (extra != 0 || tx_ready !== 1'b1) begin
            nerr++; $display("FAIL strobe_queued got dones=%0d rdy=%b exp dones=0 rdy=1", extra, tx_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0]   r1, r2;
        logic [W-1:0] s1, s2;
        logic         d1, d2, rdy1;
        int           ndone;
        r1 = ref_add(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
        r2 = ref_add(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1);
        d1 = 1'b0; d2 = 1'b0; rdy1 = 1'b1; s1 = '0; s2 = '0; ndone = 0;
        @(negedge aclk);
        rx_enable = 1'b1; rx_write = 1'b1; rx_strobe = 1'b1; rx_subtract = 1'b0;
        rx_carryflag = 1'b0; rx_addend0 = 32'hFFFF_0000; rx_addend1 = 32'h0001_0000;
        @(posedge aclk); #1;
        rx_subtract = 1'b1; rx_carryflag = 1'b1;
        rx_addend0 = 32'h0000_0010; rx_addend1 = 32'h0000_0020;
        for (int i = 1; i <= 2 * (NS + 1) + 3; i++) begin
            @(posedge aclk); #1;
            if (tx_done === 1'b1) ndone++;
            if (i == NS + 1) begin d1 = tx_done; s1 = tx_sum; rdy1 = tx_ready; rx_strobe = 1'b0; end
            if (i == 2 * (NS + 1)) begin d2 = tx_done; s2 = tx_sum; end
        end
        nvec++;
        if (d1 !== 1'b1 || s1 !== r1[W-1:0] || rdy1 !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_first got done=%b sum=%h rdy=%b exp done=1 sum=%h rdy=0", d1, s1, rdy1, r1[W-1:0]);
        end
        nvec++;
        if (d2 !== 1'b1 || s2 !== r2[W-1:0] || ndone != 2) begin
            nerr++;
            $display("FAIL b2b_second got done=%b sum=%h dones=%0d exp done=1 sum=%h dones=2", d2, s2, ndone, r2[W-1:0]);
        end
    endtask

    task automatic test_enable();
        int   ndone, nbusy, lat;
        logic [W:0] r;
        for (int v = 0; v < 2; v++) begin
            @(negedge aclk);
            rx_enable = (v == 1); rx_write = (v == 0); rx_strobe = 1'b1;
            rx_addend0 = 32'h55; rx_addend1 = 32'h66;
            ndone = 0; nbusy = 0;
            for (int i = 0; i < 2 * NS + 2; i++) begin
                @(posedge aclk); #1;
                if (tx_done === 1'b1) ndone++;
                if (tx_ready !== 1'b1) nbusy++;
            end
            nvec++;
            if (ndone != 0 || nbusy != 0) begin
                nerr++; $display("FAIL no_accept_%0d got dones=%0d busy=%0d exp 0 0", v, ndone, nbusy);
            end
        end
        rx_strobe = 1'b0; rx_write = 1'b1; rx_enable = 1'b1;
        r = ref_add(32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0);
        run_op(32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0, 1'b1, lat);
        nvec++;
        if (tx_sum !== r[W-1:0] || tx_carryflag !== r[W] || lat != NS + 1) begin
            nerr++;
            $display("FAIL enable_low_run got sum=%h c=%b lat=%0d exp sum=%h c=%b lat=%0d",
                     tx_sum, tx_carryflag, lat, r[W-1:0], r[W], NS + 1);
        end
    endtask

    task automatic test_mid_run_reset();
        int lat;
        logic [W:0] r;
        run_op(32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0, 1'b0, lat);
        @(negedge aclk);
        rx_enable = 1'b1; rx_write = 1'b1; rx_strobe = 1'b1; rx_subtract = 1'b0;
        rx_carryflag = 1'b1; rx_addend0 = 32'hFFFF_FFFF; rx_addend1 = 32'hFFFF_FFFF;
        @(posedge aclk); #1;
        rx_strobe = 1'b0;
        repeat (2) @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        nvec++;
        if ({tx_sum, tx_carryflag, tx_zeroflag, tx_ready, tx_done} !== {{W{1'b0}}, 4'b0010}) begin
            nerr++;
            $display("FAIL mid_run_reset got sum=%h c=%b z=%b rdy=%b done=%b exp sum=0 c=0 z=0 rdy=1 done=0",
                     tx_sum, tx_carryflag, tx_zeroflag, tx_ready, tx_done);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        r = ref_add(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b1);
        run_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b1, 1'b0, lat);
        nvec++;
        if (tx_sum !== r[W-1:0] || tx_carryflag !== r[W] || lat != NS + 1) begin
            nerr++;
            $display("FAIL after_reset_op got sum=%h c=%b lat=%0d exp sum=%h c=%b lat=%0d",
                     tx_sum, tx_carryflag, lat, r[W-1:0], r[W], NS + 1);
        end
    endtask

    task automatic test_slice_eq_width();
        logic [W-1:0] a, b;
        logic         sub, cin;
        logic [W:0]   r;
        int           lat;
        for (int n = 0; n < 6; n++) begin
            a = (n == 0) ? 32'h7FFF_FFFF : $urandom;
            b = (n == 0) ? 32'h1 : $urandom;
            sub = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            cin = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            r = ref_add(a, b, sub, cin);
            run_op_u(a, b, sub, cin, lat);
            nvec++;
            if ({u_sum, u_carryout, u_zero} !== {r[W-1:0], r[W], (r[W-1:0] == '0)} || lat != 2) begin
                nerr++;
                $display("FAIL single_slice a=%h b=%h got sum=%h c=%b z=%b lat=%0d exp sum=%h c=%b lat=2",
                         a, b, u_sum, u_carryout, u_zero, lat, r[W-1:0], r[W]);
            end
`ifdef CARRYADDER_SLICED_OVERFLOW_EN
            nvec++;
            if (u_overflow !== ref_ovf(a, b, sub, cin)) begin
                nerr++;
                $display("FAIL single_slice_ovf a=%h b=%h got=%b exp=%b", a, b, u_overflow, ref_ovf(a, b, sub, cin));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_strobe();
        test_back_to_back();
        test_enable();
        test_mid_run_reset();
        test_slice_eq_width();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end
endmodule
